encap_pio_master: RTL and testbench

- PIO initiator for the encap register/memory space; drives the request side of the bus whose responder decodes `ENCR_MEM_ADDR_RANGE`.
- Accepts one host request at a time (read or write) and issues it on reg_bs/reg_rd/reg_wr/reg_addr/reg_din.
- Generates the clk_div sampling strobe, waits for pio_ack, captures pio_rdata, and returns a one-cycle response with status.
- Enforces a timeout on the ack, and on ack release between transactions.

---
 rtl/encap_pio_master_pkg.sv | 16 +
 rtl/encap_pio_master_clk_div.sv | 26 ++
 rtl/encap_pio_master.sv | 171 +++++++++++++++++
 tb/tb_encap_pio_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encap_pio_master_pkg.sv
// Shared definitions for the encap PIO initiator: FSM state encoding and default sizing.
package encap_pio_master_pkg;

    localparam int PIOM_DEF_NBITS         = 32;
    localparam int PIOM_DEF_CLK_DIV_RATIO = 4;
    localparam int PIOM_DEF_TIMEOUT_TICKS = 256;

    typedef enum logic [2:0] {
        PIOM_IDLE     = 3'd0,
        PIOM_ISSUE    = 3'd1,
        PIOM_WAIT_ACK = 3'd2,
        PIOM_RESP     = 3'd3,
        PIOM_WAIT_REL = 3'd4
    } piom_state_e;

endpackage

// File: rtl/encap_pio_master_clk_div.sv
// Free-running divider that produces a one-clk sampling strobe every CLK_DIV_RATIO clks.
module pio_clk_div_gen #(
    parameter int CLK_DIV_RATIO = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_clk_div
);
    localparam int CW = (CLK_DIV_RATIO > 1) ? $clog2(CLK_DIV_RATIO) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV_RATIO - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_clk_div = (r_count == LAST);

endmodule

// File: rtl/encap_pio_master.sv
// PIO initiator: issues one host read/write on the reg_* bus, waits for pio_ack with a
// clk_div-based timeout, returns a one-cycle response, then waits for ack release.
module encap_pio_master
    import encap_pio_master_pkg::*;
#(
    parameter int PIO_NBITS     = PIOM_DEF_NBITS,
    parameter int CLK_DIV_RATIO = PIOM_DEF_CLK_DIV_RATIO,
    parameter int TIMEOUT_TICKS = PIOM_DEF_TIMEOUT_TICKS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_req,
    input  logic                 host_wr,
    input  logic [PIO_NBITS-1:0] host_addr,
    input  logic [PIO_NBITS-1:0] host_wdata,
    output logic                 host_ready,
    output logic                 host_resp_valid,
    output logic [PIO_NBITS-1:0] host_rdata,
    output logic                 host_resp_timeout,
    output logic                 host_resp_unmapped,
    output logic                 ack_stuck,
    output logic                 clk_div,
    output logic                 reg_bs,
    output logic                 reg_rd,
    output logic                 reg_wr,
    output logic [PIO_NBITS-1:0] reg_addr,
    output logic [PIO_NBITS-1:0] reg_din,
    input  logic                 pio_ack,
    input  logic                 pio_rvalid,
    input  logic [PIO_NBITS-1:0] pio_rdata
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0] TICK_MAX  = TW'(TIMEOUT_TICKS);

    piom_state_e          r_state, w_nextState;
    logic                 r_wr;
    logic [PIO_NBITS-1:0] r_addr, r_din, r_rdata;
    logic                 r_timeout, r_unmapped, r_stuck;
    logic [TW-1:0]        r_tick;

    logic w_clkDiv, w_lastTick;
    logic w_latch, w_tickClr, w_tickInc, w_ackDone, w_toDone, w_setStuck;

    pio_clk_div_gen #(
        .CLK_DIV_RATIO(CLK_DIV_RATIO)
    ) u_clk_div (
        .i_clk    (clk),
        .i_rst    (rst),
        .o_clk_div(w_clkDiv)
    );

    // The final tick is the clk_div pulse that would carry the counter to TIMEOUT_TICKS.
    assign w_lastTick = w_clkDiv && (r_tick == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PIOM_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        host_ready      = 1'b0;
        host_resp_valid = 1'b0;
        reg_bs          = 1'b0;
        reg_rd          = 1'b0;
        reg_wr          = 1'b0;
        w_latch         = 1'b0;
        w_tickClr       = 1'b0;
        w_tickInc       = 1'b0;
        w_ackDone       = 1'b0;
        w_toDone        = 1'b0;
        w_setStuck      = 1'b0;
        unique case (r_state)
            PIOM_IDLE: begin
                host_ready = ~rst;
                if (host_req) begin
                    w_latch     = 1'b1;
                    w_nextState = PIOM_ISSUE;
                end
            end
            PIOM_ISSUE: begin
                reg_bs      = 1'b1;
                reg_rd      = ~r_wr;
                reg_wr      = r_wr;
                w_tickClr   = 1'b1;
                w_nextState = PIOM_WAIT_ACK;
            end
            PIOM_WAIT_ACK: begin
                reg_bs    = 1'b1;
                w_tickInc = w_clkDiv;
                // Ack is checked first so it wins over a coincident final tick.
                if (pio_ack) begin
                    w_ackDone   = 1'b1;
                    w_nextState = PIOM_RESP;
                end else if (w_lastTick) begin
                    w_toDone    = 1'b1;
                    w_nextState = PIOM_RESP;
                end
            end
            PIOM_RESP: begin
                host_resp_valid = 1'b1;
                if (r_timeout) begin
                    w_nextState = PIOM_IDLE;
                end else begin
                    w_tickClr   = 1'b1;
                    w_nextState = PIOM_WAIT_REL;
                end
            end
            PIOM_WAIT_REL: begin
                w_tickInc = w_clkDiv;
                if (!pio_ack) begin
                    w_nextState = PIOM_IDLE;
                end else if (w_lastTick) begin
                    w_setStuck  = 1'b1;
                    w_nextState = PIOM_IDLE;
                end
            end
            default: w_nextState = PIOM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_rdata    <= '0;
            r_timeout  <= 1'b0;
            r_unmapped <= 1'b0;
            r_stuck    <= 1'b0;
            r_tick     <= '0;
        end else begin
            if (w_latch) begin
                r_wr   <= host_wr;
                r_addr <= host_addr;
                r_din  <= host_wdata;
            end
            if (w_tickClr) begin
                r_tick <= '0;
            end else if (w_tickInc && (r_tick != TICK_MAX)) begin
                r_tick <= r_tick + TW'(1);
            end
            // Write completions and misses return zero data so stale bus values never leak.
            if (w_ackDone) begin
                r_rdata    <= (pio_rvalid && !r_wr) ? pio_rdata : '0;
                r_timeout  <= 1'b0;
                r_unmapped <= ~pio_rvalid;
            end else if (w_toDone) begin
                r_rdata    <= '0;
                r_timeout  <= 1'b1;
                r_unmapped <= 1'b0;
            end
            if (w_setStuck) begin
                r_stuck <= 1'b1;
            end
        end
    end

    assign host_rdata         = r_rdata;
    assign host_resp_timeout  = r_timeout;
    assign host_resp_unmapped = r_unmapped;
    assign ack_stuck          = r_stuck;
    assign clk_div            = w_clkDiv;
    assign reg_addr           = r_addr;
    assign reg_din            = r_din;

endmodule

// File: tb/tb_encap_pio_master.sv
// Directed bench for encap_pio_master: stimulus pushes expected responses into a scoreboard
// queue, and a negedge monitor pops and compares whenever host_resp_valid is seen.
module tb_encap_pio_master;
    localparam int NB  = 32;
    localparam int DIV = 4;
    localparam int TMO = 8;

    typedef struct packed {
        logic [NB-1:0] rdata;
        logic          timeout;
        logic          unmapped;
    } resp_t;

    typedef struct {
        string        name;
        logic [127:0] act;
        logic [127:0] exp;
    } chk_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_req = 1'b0;
    logic          host_wr = 1'b0;
    logic [NB-1:0] host_addr = '0;
    logic [NB-1:0] host_wdata = '0;
    logic          host_ready, host_resp_valid, host_resp_timeout, host_resp_unmapped;
    logic [NB-1:0] host_rdata;
    logic          ack_stuck, clk_div, reg_bs, reg_rd, reg_wr;
    logic [NB-1:0] reg_addr, reg_din;
    logic          pio_ack = 1'b0;
    logic          pio_rvalid = 1'b0;
    logic [NB-1:0] pio_rdata = '0;

    resp_t expQ[$];
    chk_t  chkQ[$];
    int    errors = 0;
    int    checks = 0;

    encap_pio_master #(
        .PIO_NBITS    (NB),
        .CLK_DIV_RATIO(DIV),
        .TIMEOUT_TICKS(TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .host_req          (host_req),
        .host_wr           (host_wr),
        .host_addr         (host_addr),
        .host_wdata        (host_wdata),
        .host_ready        (host_ready),
        .host_resp_valid   (host_resp_valid),
        .host_rdata        (host_rdata),
        .host_resp_timeout (host_resp_timeout),
        .host_resp_unmapped(host_resp_unmapped),
        .ack_stuck         (ack_stuck),
        .clk_div           (clk_div),
        .reg_bs            (reg_bs),
        .reg_rd            (reg_rd),
        .reg_wr            (reg_wr),
        .reg_addr          (reg_addr),
        .reg_din           (reg_din),
        .pio_ack           (pio_ack),
        .pio_rvalid        (pio_rvalid),
        .pio_rdata         (pio_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish (actual=running required=finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: the only process that touches the counters.
    always @(negedge clk) begin
        if (host_resp_valid) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_resp: actual rdata=%0h to=%0b um=%0b required=no response",
                         host_rdata, host_resp_timeout, host_resp_unmapped);
            end else begin
                resp_t e;
                e = expQ.pop_front();
                if ({host_rdata, host_resp_timeout, host_resp_unmapped} !== e) begin
                    errors++;
                    $display("[TB] FAIL resp: actual rdata=%0h to=%0b um=%0b required rdata=%0h to=%0b um=%0b",
                             host_rdata, host_resp_timeout, host_resp_unmapped,
                             e.rdata, e.timeout, e.unmapped);
                end
            end
        end
        while (chkQ.size() > 0) begin
            chk_t c;
            c = chkQ.pop_front();
            checks++;
            if (c.act !== c.exp) begin
                errors++;
                $display("[TB] FAIL %s: actual=%0h required=%0h", c.name, c.act, c.exp);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        chkQ.push_back('{name, act, exp});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [127:0] allOutputs();
        return 128'({host_ready, host_resp_valid, host_rdata, host_resp_timeout, host_resp_unmapped,
                     ack_stuck, clk_div, reg_bs, reg_rd, reg_wr, reg_addr, reg_din});
    endfunction

    // Waits for host_ready, presents one request, and returns at the ISSUE-cycle negedge.
    task automatic applyStimulus(input logic wr, input logic [NB-1:0] addr, input logic [NB-1:0] wdata);
        int n = 0;
        step();
        while (!host_ready && n < 100) begin
            step();
            n++;
        end
        checkOutput("ready_wait", 128'(host_ready), 128'(1));
        host_req   = 1'b1;
        host_wr    = wr;
        host_addr  = addr;
        host_wdata = wdata;
        step();
        host_req = 1'b0;
        checkOutput("issue_rd", 128'(reg_rd), 128'(!wr));
        checkOutput("issue_wr", 128'(reg_wr), 128'(wr));
        checkOutput("issue_bs", 128'(reg_bs), 128'(1));
        checkOutput("issue_addr", 128'(reg_addr), 128'(addr));
        checkOutput("issue_din", 128'(reg_din), 128'(wdata));
    endtask

    // Counts cycles after the last reset edge until the first clk_div strobe.
    task automatic checkFirstDiv(input string name);
        int n = 1;
        rst = 1'b0;
        checkOutput({name, "_div_low"}, 128'(clk_div), 128'(0));
        while (n < 50) begin
            step();
            n++;
            if (clk_div) break;
        end
        checkOutput(name, 128'(n), 128'(DIV));
    endtask

    initial begin
        int n;
        int pulses;

        // Reset state
        step();
        step();
        checkOutput("reset_outputs", allOutputs(), 128'(0));
        checkFirstDiv("first_div");

        // Read acked 3 clks after reg_rd, ack released 4 clks later
        applyStimulus(1'b0, 32'h0000_0010, 32'h0);
        step();
        checkOutput("rd_pulse_end", 128'({reg_rd, reg_wr}), 128'(0));
        checkOutput("bs_held", 128'(reg_bs), 128'(1));
        step();
        step();
        pio_ack = 1'b1; pio_rvalid = 1'b1; pio_rdata = 32'hDEAD_BEEF;
        expQ.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0});
        step();
        checkOutput("resp_latency", 128'(host_resp_valid), 128'(1));
        checkOutput("resp_bs_low", 128'(reg_bs), 128'(0));
        step();
        step();
        step();
        checkOutput("ready_before_rel", 128'(host_ready), 128'(0));
        pio_ack = 1'b0; pio_rvalid = 1'b0;
        step();
        checkOutput("ready_after_rel", 128'(host_ready), 128'(1));

        // Write: single reg_wr pulse, held addr/data, zero read data
        applyStimulus(1'b1, 32'h0000_0040, 32'h1234_5678);
        step();
        checkOutput("wr_pulse_end", 128'({reg_rd, reg_wr}), 128'(0));
        checkOutput("wr_addr_held", 128'(reg_addr), 128'(32'h40));
        checkOutput("wr_din_held", 128'(reg_din), 128'(32'h1234_5678));
        pio_ack = 1'b1; pio_rvalid = 1'b1; pio_rdata = 32'hFFFF_FFFF;
        expQ.push_back('{32'h0, 1'b0, 1'b0});
        step();
        checkOutput("wr_resp_latency", 128'(host_resp_valid), 128'(1));
        pio_ack = 1'b0; pio_rvalid = 1'b0;

        // Unmapped read
        applyStimulus(1'b0, 32'h0000_9000, 32'h0);
        step();
        pio_ack = 1'b1; pio_rvalid = 1'b0; pio_rdata = 32'h5555_5555;
        expQ.push_back('{32'h0, 1'b0, 1'b1});
        step();
        checkOutput("um_resp_latency", 128'(host_resp_valid), 128'(1));
        pio_ack = 1'b0;

        // No ack: timeout after TMO clk_div pulses
        applyStimulus(1'b0, 32'h0000_0080, 32'h0);
        expQ.push_back('{32'h0, 1'b1, 1'b0});
        pulses = 0; n = 0;
        step();
        while (!host_resp_valid && n < 100) begin
            if (clk_div) pulses++;
            step();
            n++;
        end
        checkOutput("to_resp_seen", 128'(host_resp_valid), 128'(1));
        checkOutput("to_pulses", 128'(pulses), 128'(TMO));
        checkOutput("to_bs_low", 128'(reg_bs), 128'(0));

        // Ack coinciding with the final tick wins
        applyStimulus(1'b0, 32'h0000_00C0, 32'h0);
        pulses = 0; n = 0;
        step();
        while (n < 100) begin
            if (clk_div) begin
                if (pulses == TMO - 1) break;
                pulses++;
            end
            step();
            n++;
        end
        pio_ack = 1'b1; pio_rvalid = 1'b1; pio_rdata = 32'hA5A5_A5A5;
        expQ.push_back('{32'hA5A5_A5A5, 1'b0, 1'b0});
        step();
        checkOutput("tie_resp_latency", 128'(host_resp_valid), 128'(1));
        pio_ack = 1'b0; pio_rvalid = 1'b0;

        // Ack never released: ack_stuck after TMO pulses, sticky until reset
        applyStimulus(1'b0, 32'h0000_0100, 32'h0);
        step();
        pio_ack = 1'b1; pio_rvalid = 1'b1; pio_rdata = 32'h0000_CAFE;
        expQ.push_back('{32'h0000_CAFE, 1'b0, 1'b0});
        step();
        checkOutput("stuck_resp_latency", 128'(host_resp_valid), 128'(1));
        pulses = 0; n = 0;
        step();
        while (!ack_stuck && n < 100) begin
            if (clk_div) pulses++;
            step();
            n++;
        end
        checkOutput("stuck_set", 128'(ack_stuck), 128'(1));
        checkOutput("stuck_pulses", 128'(pulses), 128'(TMO));
        checkOutput("stuck_idle", 128'(host_ready), 128'(1));
        pio_ack = 1'b0; pio_rvalid = 1'b0;
        step();
        step();
        step();
        checkOutput("stuck_sticky", 128'(ack_stuck), 128'(1));

        // Reset during WAIT_ACK abandons silently and clears ack_stuck
        applyStimulus(1'b0, 32'h0000_0140, 32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        checkOutput("midrst_outputs", allOutputs(), 128'(0));
        step();
        step();
        checkFirstDiv("rerst_first_div");

        // Normal read after reset
        applyStimulus(1'b0, 32'h0000_0180, 32'h0);
        step();
        pio_ack = 1'b1; pio_rvalid = 1'b1; pio_rdata = 32'h1357_9BDF;
        expQ.push_back('{32'h1357_9BDF, 1'b0, 1'b0});
        step();
        checkOutput("post_rst_latency", 128'(host_resp_valid), 128'(1));
        pio_ack = 1'b0; pio_rvalid = 1'b0;

        step();
        step();
        checkOutput("sb_empty", 128'(expQ.size()), 128'(0));
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
